data_mem_unit: RTL and testbench
================================

# data_mem_unit

Parametrised RV32I data memory with a request/response handshake. It decodes load/store width from funct3, generates byte-lane masks, aligns and sign/zero-extends load data, and flags misaligned, out-of-range or illegal accesses. A programmable wait-state count lets it model slower memories. It sits between the CPU load/store stage and the word-organised data RAM.

## Interface
- DEPTH, 4096: number of 32-bit words; power of two, ≥ 4.
- WAIT_CYCLES, 0: extra cycles between request acceptance and response, 0..15.
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3: 0 B, 1 H, 2 W, 4 BU, 5 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  access rejected; memory untouched.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready = 1. On req_valid && req_ready, the request is accepted:
  - If WAIT_CYCLES = 0, go to RESP.
  - Otherwise load the wait counter with WAIT_CYCLES and go to WAIT.
- WAIT: counter decrements each cycle; at 1, go to RESP.
- RESP: rsp_valid = 1; outputs stay stable until rsp_ready, then return to IDLE. There is no same-cycle accept of a new request in RESP.
- Word index = req_addr[2+$clog2(DEPTH)-1:2].
- Error conditions (any one sets rsp_err, suppresses the RAM access and forces rsp_rdata = 0):
  - req_addr[31:2] ≥ DEPTH;
  - H/HU with addr[0] = 1;
  - W with addr[1:0] ≠ 0;
  - funct3 ∈ {3, 6, 7};
  - store with funct3 ∈ {4, 5}.
- Store mask:
  - B: 4'b0001 << addr[1:0];
  - H: 4'b0011 << addr[1:0];
  - W: 4'b1111.
  - wdata is replicated across lanes (byte ×4, half ×2).
  - The write occurs on the acceptance edge.
- Load:
  - The RAM word is read synchronously on the acceptance edge; addr[1:0] and funct3 are registered.
  - The selected lane is shifted down. B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes through.
  - The result is captured into the rsp_rdata register on entry to RESP.
- RAM contents are zero at time 0 and are not affected by rst_n.

## Timing
- Reset values (while rst_n low, and after release): state IDLE, req_ready 0 during reset then 1, rsp_valid 0, rsp_rdata 0, rsp_err 0, wait counter 0.
- Latency: rsp_valid rises WAIT_CYCLES+1 cycles after the acceptance edge. Minimum throughput is one request per WAIT_CYCLES+2 cycles, with rsp_ready held high.
- A store is visible to a load accepted on any later cycle. Read-after-write to the same word therefore returns the new data.
- Reset asserted in WAIT/RESP: the response is dropped. A store already accepted remains written.
- rsp_ready asserted outside RESP is ignored. req_valid outside IDLE is ignored; the request is not consumed.

## Structure
- Package dmem_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - state enum {IDLE, WAIT, RESP};
  - function for mask generation;
  - function for load extension.
- Sub-module dmem_ram (DEPTH): single-port, synchronous-read, byte-enable 32-bit RAM, block-RAM inferable, zero-initialised. The controller FSM, error check and extension live in data_mem_unit.
- Wait counter width: 4 bits.

## Test plan
- WAIT_CYCLES=0: SW 0xDEADBEEF @0x10, then LW @0x10 -> rsp_rdata 0xDEADBEEF, rsp_err 0, rsp_valid exactly 1 cycle after each acceptance.
- After the above: LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x12 -> 0xFFFFDEAD; LHU @0x10 -> 0x0000BEEF.
- SB 0x55 @0x11, then LW @0x10 -> 0xDEAD55EF; SH 0x1234 @0x12, then LW -> 0x123455EF.
- Errors:
  - LW @0x12 -> rsp_err 1, rdata 0;
  - SH @0x21 -> rsp_err 1, word 0x20 unchanged;
  - LW @ DEPTH*4 -> rsp_err 1;
  - funct3 = 3 -> rsp_err 1.
- WAIT_CYCLES=3, rsp_ready held low for 5 cycles in RESP: rsp_valid rises 4 cycles after acceptance and holds with stable data; req_ready stays 0 until the response handshake.
- Assert rst_n low during WAIT after an SW 0xA5A5A5A5 @0x40: all outputs return to reset values, no response is issued; a subsequent LW @0x40 returns 0xA5A5A5A5.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the RV32I data memory: funct3 codes, FSM states,
// store byte-mask/data replication and load alignment/extension helpers.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  // Low two funct3 bits carry the access size for both signed and unsigned forms.
  function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'd0:    store_mask = 4'b0001 << off;
      2'd1:    store_mask = 4'b0011 << off;
      default: store_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'd0:    store_data = {4{wd[7:0]}};
      2'd1:    store_data = {2{wd[15:0]}};
      default: store_data = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] off,
                                           input logic [2:0] f3);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (f3)
      F3_B:    load_ext = {{24{sh[7]}}, sh[7:0]};
      F3_H:    load_ext = {{16{sh[15]}}, sh[15:0]};
      F3_BU:   load_ext = {24'd0, sh[7:0]};
      F3_HU:   load_ext = {16'd0, sh[15:0]};
      default: load_ext = sh;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port word RAM with byte enables and registered read data.
// Read data only updates on a load, so it stays stable across wait/response.
module dmem_ram #(
  parameter int DEPTH = 4096
) (
  input  logic                     i_clk,
  input  logic                     i_en,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [3:0]               i_be,
  input  logic [31:0]              i_wdata,
  output logic [31:0]              o_rdata
);

  logic [31:0] r_mem [DEPTH] = '{default: '0};
  logic [31:0] r_rdata = '0;

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int b = 0; b < 4; b++)
          if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_unit.sv
// RV32I data memory front end: request/response FSM with programmable wait
// states, access checking, byte-lane store masking and load extension.
module data_mem_unit
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 4096,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  localparam int AW = $clog2(DEPTH);

  state_t      r_state, w_next;
  logic [3:0]  r_wcnt;
  logic        r_err, r_we;
  logic [1:0]  r_off;
  logic [2:0]  r_f3;
  logic        w_acc, w_err, w_oor;
  logic [31:0] w_q;

  assign w_acc = i_req_valid && o_req_ready;
  assign w_oor = 32'(i_req_addr[31:2]) >= 32'(DEPTH);

  always_comb begin
    w_err = w_oor;
    case (i_req_funct3)
      F3_B, F3_BU: ;
      F3_H, F3_HU: if (i_req_addr[0]) w_err = 1'b1;
      F3_W:        if (|i_req_addr[1:0]) w_err = 1'b1;
      default:     w_err = 1'b1;
    endcase
    if (i_req_we && (i_req_funct3 == F3_BU || i_req_funct3 == F3_HU)) w_err = 1'b1;
  end

  dmem_ram #(.DEPTH(DEPTH)) u_ram (
    .i_clk   (i_clk),
    .i_en    (w_acc && !w_err),
    .i_we    (i_req_we),
    .i_addr  (i_req_addr[AW+1:2]),
    .i_be    (store_mask(i_req_funct3, i_req_addr[1:0])),
    .i_wdata (store_data(i_req_funct3, i_req_wdata)),
    .o_rdata (w_q)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_acc) w_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT:    if (r_wcnt == 4'd1) w_next = RESP;
      RESP:    if (i_rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // RAM read data is held until the next load, so extension can be combinational.
  always_comb begin
    o_req_ready = (r_state == IDLE) && i_rst_n;
    o_rsp_valid = (r_state == RESP);
    o_rsp_err   = (r_state == RESP) && r_err;
    o_rsp_rdata = '0;
    if (r_state == RESP && !r_err && !r_we) o_rsp_rdata = load_ext(w_q, r_off, r_f3);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wcnt <= '0;
      r_err  <= 1'b0;
      r_we   <= 1'b0;
      r_off  <= '0;
      r_f3   <= '0;
    end else begin
      if (w_acc) begin
        r_wcnt <= 4'(WAIT_CYCLES);
        r_err  <= w_err;
        r_we   <= i_req_we;
        r_off  <= i_req_addr[1:0];
        r_f3   <= i_req_funct3;
      end else if (r_state == WAIT) begin
        r_wcnt <= r_wcnt - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_unit.sv
// Bench for data_mem_unit: directed table on a zero-wait instance, randomized
// traffic against a byte-level memory model, and wait/hold/reset sequences.
module tb_data_mem_unit;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n     [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [2:0]  req_f3    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] mem_m [DEPTH];

  always #5 clk = ~clk;

  data_mem_unit #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n[0]), .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
    .i_req_we(req_we[0]), .i_req_funct3(req_f3[0]), .i_req_addr(req_addr[0]),
    .i_req_wdata(req_wdata[0]), .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready[0]),
    .o_rsp_rdata(rsp_rdata[0]), .o_rsp_err(rsp_err[0]));

  data_mem_unit #(.DEPTH(DEPTH), .WAIT_CYCLES(3)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n[1]), .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
    .i_req_we(req_we[1]), .i_req_funct3(req_f3[1]), .i_req_addr(req_addr[1]),
    .i_req_wdata(req_wdata[1]), .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready[1]),
    .o_rsp_rdata(rsp_rdata[1]), .o_rsp_err(rsp_err[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: access size/alignment rules applied byte by byte on a word array.
  task automatic model(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                       input bit [31:0] wd, output bit [31:0] rd, output bit err);
    int size, off;
    bit sgn, ld_only;
    longint unsigned word, val;
    size = 4; sgn = 0; ld_only = 0; err = 0; rd = 0;
    off  = int'(addr % 4);
    word = addr / 4;
    case (f3)
      3'd0: begin size = 1; sgn = 1; end
      3'd1: begin size = 2; sgn = 1; end
      3'd2: size = 4;
      3'd4: begin size = 1; ld_only = 1; end
      3'd5: begin size = 2; ld_only = 1; end
      default: err = 1;
    endcase
    if (word >= DEPTH) err = 1;
    if (off % size != 0) err = 1;
    if (we && ld_only) err = 1;
    if (err) return;
    if (we) begin
      for (int k = 0; k < size; k++) begin
        mem_m[word] = (mem_m[word] & ~(32'hFF << (8*(off+k))))
                    | (((wd >> (8*k)) & 32'hFF) << (8*(off+k)));
      end
    end else begin
      val = (longint'(mem_m[word]) >> (8*off)) & ((64'd1 << (8*size)) - 1);
      if (sgn && size < 4 && val >= (64'd1 << (8*size-1))) val = val + 64'hFFFF_FFFF_0000_0000
                                                                  - (64'd1 << (8*size))
                                                                  + 64'h1_0000_0000;
      rd = val[31:0];
    end
  endtask

  task automatic txn(input int d, input bit we, input bit [2:0] f3, input bit [31:0] addr,
                     input bit [31:0] wd, output bit [31:0] rd, output bit err, output int lat);
    @(negedge clk);
    req_valid[d] = 1'b1; req_we[d] = we; req_f3[d] = f3;
    req_addr[d] = addr; req_wdata[d] = wd; rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    lat = 1;
    while (!rsp_valid[d] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rd  = rsp_rdata[d];
    err = rsp_err[d];
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit        we;
    bit [2:0]  f3;
    bit [31:0] addr;
    bit [31:0] wd;
    bit [31:0] exp_rd;
    bit        exp_err;
  } vec_t;

  initial begin
    vec_t vt[$];
    bit [31:0] rd, erd, hold_rd;
    bit err, eerr, seen;
    int lat;

    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 0; req_valid[d] = 0; req_we[d] = 0; req_f3[d] = 0;
      req_addr[d] = 0; req_wdata[d] = 0; rsp_ready[d] = 0;
    end
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_req_ready", 32'(req_ready[d]), 0);
      chk("rst_rsp_valid", 32'(rsp_valid[d]), 0);
      chk("rst_rsp_rdata", rsp_rdata[d], 0);
      chk("rst_rsp_err",   32'(rsp_err[d]), 0);
    end
    @(negedge clk); rst_n[0] = 1; rst_n[1] = 1;
    @(posedge clk); #1;
    chk("post_rst_ready0", 32'(req_ready[0]), 1);
    chk("post_rst_ready1", 32'(req_ready[1]), 1);

    vt = '{
      '{1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0,        0},
      '{0, 3'd2, 32'h10, 32'h0,        32'hDEADBEEF, 0},
      '{0, 3'd0, 32'h13, 32'h0,        32'hFFFFFFDE, 0},
      '{0, 3'd4, 32'h13, 32'h0,        32'h000000DE, 0},
      '{0, 3'd1, 32'h12, 32'h0,        32'hFFFFDEAD, 0},
      '{0, 3'd5, 32'h10, 32'h0,        32'h0000BEEF, 0},
      '{1, 3'd0, 32'h11, 32'h55,       32'h0,        0},
      '{0, 3'd2, 32'h10, 32'h0,        32'hDEAD55EF, 0},
      '{1, 3'd1, 32'h12, 32'h1234,     32'h0,        0},
      '{0, 3'd2, 32'h10, 32'h0,        32'h123455EF, 0},
      '{0, 3'd2, 32'h12, 32'h0,        32'h0,        1},
      '{1, 3'd2, 32'h20, 32'hCAFEF00D, 32'h0,        0},
      '{1, 3'd1, 32'h21, 32'hFFFF,     32'h0,        1},
      '{0, 3'd2, 32'h20, 32'h0,        32'hCAFEF00D, 0},
      '{0, 3'd2, DEPTH*4, 32'h0,       32'h0,        1},
      '{0, 3'd3, 32'h0,  32'h0,        32'h0,        1},
      '{1, 3'd4, 32'h20, 32'h12,       32'h0,        1},
      '{0, 3'd0, 32'h21, 32'h0,        32'hFFFFFFF0, 0}
    };
    foreach (vt[i]) begin
      model(vt[i].we, vt[i].f3, vt[i].addr, vt[i].wd, erd, eerr);
      txn(0, vt[i].we, vt[i].f3, vt[i].addr, vt[i].wd, rd, err, lat);
      chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(vt[i].exp_err));
      chk($sformatf("vec%0d_lat", i), lat, 1);
    end

    for (int i = 0; i < 300; i++) begin
      bit we;
      bit [2:0] f3;
      bit [31:0] addr, wd, w;
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      w  = ($urandom_range(0, 9) == 0) ? 32'(DEPTH + $urandom_range(0, 100)) : 32'($urandom_range(0, 15));
      addr = (w << 2) | 32'($urandom_range(0, 3));
      wd = $urandom;
      model(we, f3, addr, wd, erd, eerr);
      txn(0, we, f3, addr, wd, rd, err, lat);
      chk($sformatf("rnd%0d_rdata", i), rd, erd);
      chk($sformatf("rnd%0d_err", i), 32'(err), 32'(eerr));
    end

    txn(1, 1, 3'd2, 32'h8, 32'h11223344, rd, err, lat);
    chk("w3_store_lat", lat, 4);
    @(negedge clk);
    req_valid[1] = 1; req_we[1] = 0; req_f3[1] = 3'd2; req_addr[1] = 32'h8; rsp_ready[1] = 0;
    @(posedge clk); #1;
    req_addr[1] = 32'h4;
    lat = 1;
    while (!rsp_valid[1] && lat < 40) begin
      chk("w3_ready_low", 32'(req_ready[1]), 0);
      @(posedge clk); #1;
      lat++;
    end
    chk("w3_load_lat", lat, 4);
    hold_rd = rsp_rdata[1];
    chk("w3_load_rdata", hold_rd, 32'h11223344);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(rsp_valid[1]), 1);
      chk("hold_rdata", rsp_rdata[1], 32'h11223344);
      chk("hold_ready", 32'(req_ready[1]), 0);
    end
    @(negedge clk); req_valid[1] = 0; rsp_ready[1] = 1;
    @(posedge clk); #1;
    chk("hs_valid_drop", 32'(rsp_valid[1]), 0);
    chk("hs_ready_back", 32'(req_ready[1]), 1);

    @(negedge clk);
    req_valid[1] = 1; req_we[1] = 1; req_f3[1] = 3'd2; req_addr[1] = 32'h40;
    req_wdata[1] = 32'hA5A5A5A5; rsp_ready[1] = 1;
    @(posedge clk); #1;
    req_valid[1] = 0;
    @(posedge clk); #1;
    rst_n[1] = 0;
    #1;
    chk("mid_rst_ready", 32'(req_ready[1]), 0);
    chk("mid_rst_valid", 32'(rsp_valid[1]), 0);
    chk("mid_rst_rdata", rsp_rdata[1], 0);
    chk("mid_rst_err",   32'(rsp_err[1]), 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n[1] = 1;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (rsp_valid[1]) seen = 1;
    end
    chk("no_rsp_after_rst", 32'(seen), 0);
    txn(1, 0, 3'd2, 32'h40, 32'h0, rd, err, lat);
    chk("after_rst_rdata", rd, 32'hA5A5A5A5);
    chk("after_rst_err", 32'(err), 0);
    chk("after_rst_lat", lat, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
